// File: rtl/seq_alu_if.sv
// +--------------------------------------------------------------------+
// | seq_alu_if : start/busy/done request bus for seq_alu               |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface seq_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [3:0]       ALUOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] H;

  modport master (
    output start, ALUOp, A, B,
    input  busy, done, C, H
  );

  modport slave (
    input  start, ALUOp, A, B,
    output busy, done, C, H
  );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
// +--------------------------------------------------------------------+
// | seq_alu : registered ALU, single-cycle ops plus iterative MULU/DIVU |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset,
  seq_alu_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [3:0]     OP_MULU  = 4'd8;
  localparam logic [3:0]     OP_DIVU  = 4'd9;

  state_t           state_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] h_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic             div_q;
  logic [SHW-1:0]   cnt_q;

  logic [WIDTH-1:0]        alu_res;
  logic                    is_multi;
  logic                    accept;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] a_signed;
  logic [WIDTH:0]          mul_sum;
  logic [WIDTH:0]          div_sh;
  logic [WIDTH:0]          div_diff;
  logic [WIDTH-1:0]        hi_d;
  logic [WIDTH-1:0]        lo_d;

  assign shamt    = bus.B[SHW-1:0];
  assign a_signed = bus.A;
  assign is_multi = (bus.ALUOp == OP_MULU) || (bus.ALUOp == OP_DIVU);
  assign accept   = bus.start && !busy_q;

  always_comb begin
    alu_res = bus.A + bus.B;
    case (bus.ALUOp)
      4'd1:    alu_res = bus.A - bus.B;
      4'd2:    alu_res = bus.A & bus.B;
      4'd3:    alu_res = bus.A | bus.B;
      4'd4:    alu_res = bus.A >> shamt;
      4'd5:    alu_res = a_signed >>> shamt;
      4'd6:    alu_res = bus.A << shamt;
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      default: alu_res = bus.A + bus.B;
    endcase
  end

  // hi_q holds the upper product half / partial remainder, lo_q the
  // multiplier being shifted out / quotient being shifted in.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (div_q) begin
      hi_d = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_q     <= '0;
      h_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + SHW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            c_q     <= lo_d;
            h_q     <= hi_d;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          if (accept) begin
            if (is_multi) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              hi_q    <= '0;
              lo_q    <= bus.A;
              b_q     <= bus.B;
              div_q   <= (bus.ALUOp == OP_DIVU);
              cnt_q   <= '0;
            end else begin
              done_q  <= 1'b1;
              c_q     <= alu_res;
              h_q     <= '0;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.C    = c_q;
  assign bus.H    = h_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// +--------------------------------------------------------------------+
// | tb_seq_alu : directed self-checking bench for seq_alu              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_seq_alu;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total  = 0;

  seq_alu_if #(.WIDTH(32)) ifc ();
  seq_alu_if #(.WIDTH(8))  ifc8 ();

  seq_alu #(.WIDTH(32)) u_dut   (.clk(clk), .reset(reset), .bus(ifc));
  seq_alu #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(ifc8));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    ifc.start = 1'b1;
    ifc.ALUOp = o;
    ifc.A     = a;
    ifc.B     = b;
    step();
    ifc.start = 1'b0;
  endtask

  // Counts busy cycles from the current one until busy drops (bounded).
  task automatic wait_busy(output int n);
    n = 0;
    while (ifc.busy && n < 200) begin
      n++;
      step();
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!ifc.done && n < 200) begin
      n++;
      step();
    end
    check(tag, 32'(ifc.done), 32'd1);
  endtask

  initial begin
    int n;
    int dones;
    ifc.start  = 1'b0; ifc.ALUOp  = 4'd0; ifc.A  = '0; ifc.B  = '0;
    ifc8.start = 1'b0; ifc8.ALUOp = 4'd0; ifc8.A = '0; ifc8.B = '0;
    step(); step(); step();
    reset = 1'b0;
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_C", ifc.C, 32'd0);
    check("rst_H", ifc.H, 32'd0);

    // Single-cycle shifts, back-to-back
    op(4'd5, 32'hf0ffffff, 32'd3);
    check("sra_done", 32'(ifc.done), 32'd1);
    check("sra_C", ifc.C, 32'hfe1fffff);
    check("sra_H", ifc.H, 32'd0);
    op(4'd4, 32'hf0ffffff, 32'd3);
    check("srl_done", 32'(ifc.done), 32'd1);
    check("srl_C", ifc.C, 32'h1e1fffff);
    op(4'd6, 32'hf0ffffff, 32'd3);
    check("sll_C", ifc.C, 32'h87fffff8);
    check("sll_busy", 32'(ifc.busy), 32'd0);
    step();
    check("idle_done", 32'(ifc.done), 32'd0);
    op(4'd2, 32'hf0f0aaaa, 32'h0ff05555);
    check("and_C", ifc.C, 32'h00f00000);
    op(4'd3, 32'hf0f0aaaa, 32'h0ff05555);
    check("or_C", ifc.C, 32'hfff0ffff);
    op(4'd12, 32'd40, 32'd2);
    check("op12_add_C", ifc.C, 32'd42);

    // MULU
    op(4'd8, 32'hffffffff, 32'd2);
    check("mul_done_lo", 32'(ifc.done), 32'd0);
    check("mul_C_hold", ifc.C, 32'd42);
    wait_busy(n);
    check("mul_busy_cycles", 32'(n), 32'd32);
    check("mul_done", 32'(ifc.done), 32'd1);
    check("mul_C", ifc.C, 32'hfffffffe);
    check("mul_H", ifc.H, 32'h00000001);
    step();
    check("mul_done_pulse", 32'(ifc.done), 32'd0);

    // DIVU
    op(4'd9, 32'd100, 32'd7);
    wait_busy(n);
    check("div_busy_cycles", 32'(n), 32'd32);
    check("div_C", ifc.C, 32'd14);
    check("div_H", ifc.H, 32'd2);
    op(4'd9, 32'd5, 32'd0);
    wait_done("div0_done");
    check("div0_C", ifc.C, 32'hffffffff);
    check("div0_H", ifc.H, 32'd5);

    // SLT / SUB
    op(4'd7, 32'hffffffff, 32'd1);
    check("slt_C", ifc.C, 32'd1);
    op(4'd7, 32'd1, 32'hffffffff);
    check("slt_false_C", ifc.C, 32'd0);
    op(4'd1, 32'd0, 32'd1);
    check("sub_C", ifc.C, 32'hffffffff);
    check("sub_H", ifc.H, 32'd0);

    // Start while busy is ignored; operand changes have no effect
    op(4'd8, 32'd3, 32'd5);
    step(); step(); step(); step();
    ifc.start = 1'b1; ifc.ALUOp = 4'd0; ifc.A = 32'd1; ifc.B = 32'd1;
    step();
    ifc.start = 1'b0;
    check("ign_done", 32'(ifc.done), 32'd0);
    check("ign_C_hold", ifc.C, 32'hffffffff);
    check("ign_busy", 32'(ifc.busy), 32'd1);
    wait_done("ign_mul_done");
    check("ign_mul_C", ifc.C, 32'd15);
    check("ign_mul_H", ifc.H, 32'd0);
    step();
    check("ign_no_extra_done", 32'(ifc.done), 32'd0);

    // Reset mid-operation
    op(4'd8, 32'd7, 32'd9);
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(ifc.busy), 32'd0);
    check("abort_done", 32'(ifc.done), 32'd0);
    check("abort_C", ifc.C, 32'd0);
    check("abort_H", ifc.H, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.done) dones++;
      step();
    end
    check("abort_no_done", 32'(dones), 32'd0);
    op(4'd0, 32'd2, 32'd3);
    check("add_C", ifc.C, 32'd5);
    check("add_done", 32'(ifc.done), 32'd1);

    // Multi-cycle start accepted in FIN
    op(4'd8, 32'd6, 32'd7);
    wait_done("b2b_mul_done");
    check("b2b_mul_C", ifc.C, 32'd42);
    ifc.start = 1'b1; ifc.ALUOp = 4'd9; ifc.A = 32'd100; ifc.B = 32'd7;
    step();
    ifc.start = 1'b0;
    check("b2b_busy", 32'(ifc.busy), 32'd1);
    check("b2b_done_lo", 32'(ifc.done), 32'd0);
    wait_busy(n);
    check("b2b_div_cycles", 32'(n), 32'd32);
    check("b2b_div_C", ifc.C, 32'd14);
    check("b2b_div_H", ifc.H, 32'd2);

    // WIDTH=8 instance
    ifc8.start = 1'b1; ifc8.ALUOp = 4'd5; ifc8.A = 8'h80; ifc8.B = 8'd9;
    step();
    ifc8.start = 1'b0;
    check("w8_sra_done", 32'(ifc8.done), 32'd1);
    check("w8_sra_C", {24'd0, ifc8.C}, 32'h000000c0);
    ifc8.start = 1'b1; ifc8.ALUOp = 4'd8; ifc8.A = 8'hff; ifc8.B = 8'hff;
    step();
    ifc8.start = 1'b0;
    n = 0;
    while (ifc8.busy && n < 50) begin
      n++;
      step();
    end
    check("w8_mul_cycles", 32'(n), 32'd8);
    check("w8_mul_C", {24'd0, ifc8.C}, 32'h00000001);
    check("w8_mul_H", {24'd0, ifc8.H}, 32'h000000fe);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the 3-bit-op combinational ALU.
- Single-cycle ops: ADD, SUB, AND, OR, SRL, SRA, SLL, SLT.
- Multi-cycle ops: unsigned multiply and unsigned divide, run on an iterative shift-add / restoring-divide datapath.
- Sits beside the datapath ALU and is driven by a start/busy/done handshake; control stalls the pipeline while busy.

Parameters:
- WIDTH, 32, operand/result width; power of two, minimum 4.
- SHW, $clog2(WIDTH), shift-amount bits taken from B; derived, do not override.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- ALUOp  input  4  operation code, sampled with start.
- A  input  WIDTH  operand A, sampled with start.
- B  input  WIDTH  operand B, sampled with start.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse; C/H are valid this cycle.
- C  output  WIDTH  main result: low product or quotient.
- H  output  WIDTH  high product or remainder; 0 for single-cycle ops.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, C=0, H=0; iteration counter=0; internal operand registers=0.
- Reset beats start.
- Reset mid-operation aborts the operation. No done is produced for it.
- ALUOp encoding:
  - 0 ADD: A+B, modulo 2^WIDTH.
  - 1 SUB: A-B, modulo 2^WIDTH.
  - 2 AND.
  - 3 OR.
  - 4 SRL: A >> B[SHW-1:0], logical.
  - 5 SRA: A >>> B[SHW-1:0], arithmetic; A treated as signed.
  - 6 SLL: A << B[SHW-1:0].
  - 7 SLT: C = {0..,1} if signed A < signed B, else 0.
  - 8 MULU: {H,C} = A*B, unsigned, 2*WIDTH bits.
  - 9 DIVU: C = A/B, H = A%B, unsigned.
  - 10..15: treated as ADD.
- Handshake:
  - start is accepted on the edge where busy=0 and reset=0.
  - start while busy=1 is ignored; no queueing.
  - Operands and ALUOp are captured on acceptance; later changes on A/B/ALUOp have no effect.
- States:
  - IDLE:
    - Accept a single-cycle op: compute, register C/H, pulse done next cycle, stay IDLE.
    - Accept op 8 or 9: load operands, counter=0, go to RUN.
  - RUN:
    - busy=1.
    - One iteration per cycle, WIDTH iterations in total.
    - After the iteration with counter=WIDTH-1, go to FIN.
  - FIN:
    - Lasts one cycle; busy=0, done=1.
    - C/H hold the final values.
    - A new start may be accepted in FIN; its handling is the same as in IDLE.
    - Go to IDLE unless a multi-cycle start is accepted, in which case go to RUN.
- Latency, for start accepted at edge k:
  - Single-cycle op: done=1 in cycle k+1; busy stays 0.
  - Multi-cycle op: busy=1 in cycles k+1..k+WIDTH; done=1 in cycle k+WIDTH+1.
- Outputs: C and H hold their last result until the next done. Intermediate iteration values never appear on C/H.
- MULU datapath: shift-add. Each iteration adds the multiplicand into the upper half when the product LSB is 1, then shifts right; WIDTH+1-bit adder keeps the carry.
- DIVU datapath: restoring divide. Each iteration shifts the remainder left, brings in the next dividend bit, subtracts B, and restores if negative.
- Divide by zero: no trap; result C = all ones, H = A, with normal latency.
- Shift amounts use only B[SHW-1:0]; upper bits of B are ignored.
- done is never high for two consecutive cycles, except when back-to-back single-cycle starts are accepted.

Test Plan:
- WIDTH=32, A=32'hf0ffffff, B=3, ALUOp=5, start 1 cycle -> next cycle done=1, C=32'hfe1fffff, H=0; ALUOp=4 -> C=32'h1e1fffff; ALUOp=6 -> C=32'h87fffff8.
- ALUOp=8, A=32'hffffffff, B=2 -> busy=1 for 32 cycles, done at k+33 with H=32'h00000001, C=32'hfffffffe.
- ALUOp=9, A=100, B=7 -> done at k+33, C=14, H=2.
- ALUOp=9, A=5, B=0 -> C=32'hffffffff, H=5.
- ALUOp=7, A=32'hffffffff, B=1 -> C=1; ALUOp=1, A=0, B=1 -> C=32'hffffffff.
- MULU start, then a second start with ALUOp=0 at cycle k+5 -> ignored; C/H unchanged until the MULU done.
- MULU start, then reset at cycle k+10 -> next cycle busy=0, done=0, C=0, H=0; a fresh ADD 2+3 -> C=5.
- Back-to-back: start DIVU accepted in the FIN cycle of a MULU -> busy rises the next cycle with no idle gap.
- WIDTH=8: SRA of 8'h80 by 9 (B[2:0]=1) -> C=8'hc0.
